// File: rtl/adder_pkg.sv
// Shared definitions for the multi-precision adder sequencer: FSM encodings and
// a counter-width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a counter that indexes 0..words-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 32'd1) ? unsigned'($clog2(words)) : 32'd1;
  endfunction

endpackage

// File: rtl/adder_skla_r2.sv
// WIDTH-bit radix-2 Kogge-Stone prefix adder; only bit 0 of ci is a carry-in.
module adder_skla_r2
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] ci,
  output logic [WIDTH:0]   po
);

  localparam int unsigned LVLS = cnt_width(WIDTH);

  logic [WIDTH-1:0] hp;
  logic [WIDTH-1:0] gen [LVLS+1];
  logic [WIDTH-1:0] pro [LVLS+1];
  logic             unused_ci;

  assign unused_ci = ^ci;

  // Carry-in is folded into bit 0's generate so the prefix tree carries it.
  always_comb begin
    hp        = a ^ b;
    gen[0]    = a & b;
    gen[0][0] = gen[0][0] | (hp[0] & ci[0]);
    pro[0]    = hp;
    for (int l = 0; l < int'(LVLS); l++) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= (1 << l)) begin
          gen[l+1][i] = gen[l][i] | (pro[l][i] & gen[l][i-(1<<l)]);
          pro[l+1][i] = pro[l][i] & pro[l][i-(1<<l)];
        end else begin
          gen[l+1][i] = gen[l][i];
          pro[l+1][i] = pro[l][i];
        end
      end
    end
  end

  always_comb begin
    po        = '0;
    po[0]     = hp[0] ^ ci[0];
    for (int i = 1; i < int'(WIDTH); i++) begin
      po[i] = hp[i] ^ gen[LVLS][i-1];
    end
    po[WIDTH] = gen[LVLS][WIDTH-1];
  end

endmodule

// File: rtl/adder_mp_seq.sv
// Multi-precision add/subtract sequencer: streams WORDS chunks of the operands
// through one WIDTH-bit adder, least-significant chunk first.
module adder_mp_seq
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH*WORDS-1:0] s_a,
  input  logic [WIDTH*WORDS-1:0] s_b,
  input  logic                   s_ci,
  input  logic                   s_sub,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*WORDS-1:0] m_sum,
  output logic                   m_co,
  output logic                   m_ovf
);

  localparam int unsigned N  = WIDTH * WORDS;
  localparam int unsigned CW = cnt_width(WORDS);

  state_e             state_q, state_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [N-1:0]       sum_q, sum_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic               m_co_q, m_co_d;
  logic               m_ovf_q, m_ovf_d;
  logic [WIDTH:0]     po;
  logic [N+WIDTH-1:0] sum_shift;

  adder_skla_r2 #(.WIDTH(WIDTH)) u_add (
    .a  (a_q[WIDTH-1:0]),
    .b  (b_q[WIDTH-1:0]),
    .ci (WIDTH'(carry_q)),
    .po (po)
  );

  // New chunk enters at the top; after WORDS shifts the full result is aligned.
  assign sum_shift = {po[WIDTH-1:0], sum_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_co_d    = m_co_q;
    m_ovf_d   = m_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          a_d       = s_a;
          b_d       = s_sub ? ~s_b : s_b;
          carry_d   = s_sub ? 1'b1 : s_ci;
          idx_d     = '0;
          s_ready_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = sum_shift[N+WIDTH-1:WIDTH];
        carry_d = po[WIDTH];
        a_d     = a_q >> WIDTH;
        b_d     = b_q >> WIDTH;
        idx_d   = idx_q + CW'(1);
        if (idx_q == CW'(WORDS - 1)) begin
          // Top chunk is in the low lanes here, so its MSBs give the sign bits.
          idx_d     = '0;
          m_valid_d = 1'b1;
          m_co_d    = po[WIDTH];
          m_ovf_d   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ po[WIDTH-1]);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_co_q    <= 1'b0;
      m_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_co_q    <= m_co_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_sum   = sum_q;
  assign m_co    = m_co_q;
  assign m_ovf   = m_ovf_q;

endmodule
